// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, FSM encoding,
// the bundled stage-control word and a saturating counter helper.
package pipe_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DWAIT = 1'b1
    } hz_state_e;

    // 5-bit major opcodes, id_inst[15:11]
    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_SIIC  = 5'b00010;
    localparam logic [4:0] OP_RTI   = 5'b00011;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_SHIFT = 5'b11010;
    localparam logic [4:0] OP_ARITH = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
        logic pc_redirect;
    } hz_ctl_t;

    localparam hz_ctl_t CTL_NORMAL   = 8'b1111_0000;
    localparam hz_ctl_t CTL_FREEZE   = 8'b0000_0010;
    localparam hz_ctl_t CTL_REDIRECT = 8'b1111_1101;
    localparam hz_ctl_t CTL_LOADUSE  = 8'b0011_0100;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/inst_src_decode.sv
// Source-register decode for the instruction in ID: which of the two register
// fields the instruction actually reads.
module inst_src_decode
    import pipe_pkg::*;
(
    input  logic [15:0] inst,
    output logic [2:0]  src1,
    output logic [2:0]  src2,
    output logic        src1_vld,
    output logic        src2_vld
);

    logic [4:0] opc_s;

    assign opc_s = inst[15:11];
    assign src1  = inst[10:8];
    assign src2  = inst[7:5];

    // Classify the opcode into two-source, one-source or no-source
    always_comb begin
        src1_vld = 1'b0;
        src2_vld = 1'b0;
        case (opc_s)
            OP_ARITH, OP_SHIFT, OP_SEQ, OP_SLT, OP_SLE, OP_SCO,
            OP_BTR, OP_ST, OP_STU: begin
                src1_vld = 1'b1;
                src2_vld = 1'b1;
            end
            OP_ADDI, OP_SUBI, OP_XORI, OP_ANDNI,
            OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI,
            OP_LD, OP_SLBI, OP_JR, OP_JALR,
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
                src1_vld = 1'b1;
                src2_vld = 1'b0;
            end
            default: begin
                src1_vld = 1'b0;
                src2_vld = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: data-memory wait freeze, branch
// redirect and load-use interlock, with stall counter and wait watchdog.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter logic [7:0] WDOG_MAX = 8'd255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_inst,
    input  logic [2:0]  ex_dest,
    input  logic        ex_wr,
    input  logic        ex_is_load,
    input  logic        br_taken,
    input  logic        dmem_req,
    input  logic        dmem_done,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        memwb_bubble,
    output logic        pc_redirect,
    output logic [15:0] stall_cnt,
    output logic        err_timeout
);

    hz_state_e   state_r;
    hz_state_e   state_nxt_s;
    hz_ctl_t     ctl_s;
    logic [7:0]  wdog_r;
    logic [7:0]  wdog_nxt_s;
    logic [15:0] stall_cnt_r;
    logic        err_r;
    logic [2:0]  src1_s;
    logic [2:0]  src2_s;
    logic        src1_vld_s;
    logic        src2_vld_s;
    logic        load_use_s;
    logic        mem_miss_s;

    inst_src_decode u_src_decode (
        .inst     (id_inst),
        .src1     (src1_s),
        .src2     (src2_s),
        .src1_vld (src1_vld_s),
        .src2_vld (src2_vld_s)
    );

    assign load_use_s = ex_is_load & ex_wr &
                        ((src1_vld_s & (src1_s == ex_dest)) |
                         (src2_vld_s & (src2_s == ex_dest)));
    assign mem_miss_s = dmem_req & ~dmem_done;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (mem_miss_s) begin
                    state_nxt_s = ST_DWAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DWAIT: begin
                if (dmem_done) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DWAIT;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM output decode; memory wait outranks redirect, which outranks load-use
    always_comb begin
        ctl_s = CTL_NORMAL;
        if (!rst) begin
            ctl_s = CTL_NORMAL;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mem_miss_s) begin
                        ctl_s = CTL_FREEZE;
                    end else if (br_taken) begin
                        ctl_s = CTL_REDIRECT;
                    end else if (load_use_s) begin
                        ctl_s = CTL_LOADUSE;
                    end else begin
                        ctl_s = CTL_NORMAL;
                    end
                end
                ST_DWAIT: begin
                    if (dmem_done) begin
                        ctl_s = CTL_NORMAL;
                    end else begin
                        ctl_s = CTL_FREEZE;
                    end
                end
                default: ctl_s = CTL_NORMAL;
            endcase
        end
    end

    // Watchdog next value: zero on wait entry, saturating count while waiting
    always_comb begin
        wdog_nxt_s = wdog_r;
        if (state_r == ST_RUN) begin
            if (state_nxt_s == ST_DWAIT) begin
                wdog_nxt_s = 8'd0;
            end else begin
                wdog_nxt_s = wdog_r;
            end
        end else if (wdog_r != 8'hFF) begin
            wdog_nxt_s = wdog_r + 8'd1;
        end else begin
            wdog_nxt_s = wdog_r;
        end
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_r <= 8'd0;
            err_r  <= 1'b0;
        end else begin
            wdog_r <= wdog_nxt_s;
            err_r  <= err_r | ((state_r == ST_DWAIT) && (wdog_nxt_s >= WDOG_MAX));
        end
    end

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= 16'd0;
        end else if (!ctl_s.pc_en) begin
            stall_cnt_r <= sat_inc16(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign pc_en        = ctl_s.pc_en;
    assign ifid_en      = ctl_s.ifid_en;
    assign idex_en      = ctl_s.idex_en;
    assign exmem_en     = ctl_s.exmem_en;
    assign ifid_flush   = ctl_s.ifid_flush;
    assign idex_bubble  = ctl_s.idex_bubble;
    assign memwb_bubble = ctl_s.memwb_bubble;
    assign pc_redirect  = ctl_s.pc_redirect;
    // Counters read as zero for the whole time reset is held, not only after the edge
    assign stall_cnt    = rst ? stall_cnt_r : 16'd0;
    assign err_timeout  = rst ? err_r : 1'b0;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter WDOG_MAX, default 8'd255, meaning the number of DWAIT cycles after which err_timeout sets.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port id_inst  input  16  instruction in ID.
REQ-005 SHALL have port ex_dest  input  3  destination register of the EX instruction.
REQ-006 SHALL have port ex_wr  input  1  the EX instruction writes a register.
REQ-007 SHALL have port ex_is_load  input  1  the EX instruction is a load.
REQ-008 SHALL have port br_taken  input  1  EX resolved a taken branch or jump.
REQ-009 SHALL have port dmem_req  input  1  MEM issues a data-memory access.
REQ-010 SHALL have port dmem_done  input  1  data memory completes the access this cycle.
REQ-011 SHALL have port pc_en, ifid_en, idex_en, exmem_en  output  1 each  stage-register load enables.
REQ-012 SHALL have port ifid_flush, idex_bubble, memwb_bubble  output  1 each  NOP insertion.
REQ-013 SHALL have port pc_redirect  output  1  PC selects the EX target.
REQ-014 SHALL have port stall_cnt  output  16  saturating count of cycles with pc_en=0.
REQ-015 SHALL have port err_timeout  output  1  sticky watchdog error flag.

Function
REQ-016 SHALL implement FSM states RUN and DWAIT, with RUN as the reset state.
REQ-017 In RUN, dmem_req=1 with dmem_done=0 SHALL drive all four enables to 0 and memwb_bubble to 1 in that same cycle, then move to DWAIT.
REQ-018 In RUN, dmem_req=1 with dmem_done=1 SHALL cause no stall.
REQ-019 In DWAIT, the block SHALL hold all enables at 0 and memwb_bubble at 1 while dmem_done=0.
REQ-020 In DWAIT, dmem_done=1 SHALL drive all enables to 1 and memwb_bubble to 0 in that cycle, then return to RUN.
REQ-021 br_taken and the load-use check SHALL be ignored in DWAIT and evaluated again in the RUN cycle after the wait ends.
REQ-022 Redirect, when in RUN with no memory stall: br_taken=1 SHALL assert pc_redirect, ifid_flush and idex_bubble for one cycle, with all enables at 1.
REQ-023 Load-use hazard SHALL be ex_is_load & ex_wr & (ex_dest equals a valid source of id_inst).
REQ-024 Source decode: R-format, BTR and store/STU read [10:8] and [7:5]; immediate ALU/shift, load, SLBI, JR/JALR and branches read [10:8]; all other opcodes have no sources.
REQ-025 On a load-use hazard in RUN with no memory stall and no br_taken: pc_en=0, ifid_en=0, idex_bubble=1, idex_en=1, exmem_en=1 for exactly one cycle.
REQ-026 Priority SHALL be memory stall > redirect > load-use, with the lower-priority actions suppressed.
REQ-027 Without any stall condition, outputs SHALL be: all enables 1 and all flush/bubble/redirect outputs 0.
REQ-028 stall_cnt SHALL increment every cycle with pc_en=0 and saturate at 16'hFFFF.
REQ-029 The watchdog counter (8-bit) SHALL clear on entry to DWAIT and increment in each DWAIT cycle.
REQ-030 The watchdog count reaching WDOG_MAX SHALL set err_timeout, which stays set until reset.
REQ-031 The FSM SHALL stay in DWAIT after a watchdog timeout until dmem_done arrives.

Reset
REQ-032 rst=0 at a clock edge SHALL force RUN, clear stall_cnt, the watchdog and err_timeout, and override any operation in progress, including DWAIT.
REQ-033 While rst=0, outputs SHALL be: enables 1, flush/bubble/redirect 0, stall_cnt 0, err_timeout 0.
REQ-034 The first cycle after reset deasserts SHALL evaluate inputs normally.

Structure
REQ-035 Opcode constants and the state encoding SHALL live in the shared package pipe_pkg.
REQ-036 Source-register decode SHALL be the sub-module inst_src_decode, with outputs src1, src2, src1_vld and src2_vld.
REQ-037 All outputs SHALL be decoded combinationally from the current state and the inputs; only the state and the counters are registered.

Verification
REQ-038 The bench SHALL check: id_inst=ADD r1,r2,r3, ex_is_load=1, ex_wr=1, ex_dest=3 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then normal flow.
REQ-039 The bench SHALL check: dmem_req=1 with dmem_done low for 3 cycles -> 3 frozen cycles, release on the done cycle, stall_cnt=3.
REQ-040 The bench SHALL check: br_taken=1 together with a load-use hazard in RUN -> pc_redirect=1, ifid_flush=1, idex_bubble=1, pc_en=1.
REQ-041 The bench SHALL check: br_taken=1 during DWAIT -> ignored; redirect issued in the first RUN cycle after dmem_done.
REQ-042 The bench SHALL check: dmem_done held low for 300 cycles -> err_timeout=1 from cycle 255 onward; rst=0 -> RUN, err_timeout=0, stall_cnt=0.
REQ-043 The bench SHALL check: J-format id_inst with ex_dest matching bits [10:8] -> no stall.
